// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the SPI response packer: FSM states,
// default framing constants and the payload-cap helper.
package spi_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_LEN  = 3'd2,
      ST_RD   = 3'd3,
      ST_WR   = 3'd4,
      ST_CK   = 3'd5,
      ST_DONE = 3'd6
   } state_e;

   localparam logic [7:0] HDR_BASE_DEF    = 8'h80;
   localparam logic [7:0] MAX_PAYLOAD_DEF = 8'd64;

   function automatic logic [7:0] cap_len(input logic [7:0] len, input logic [7:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/spi_rx_packer_rr_arbiter.sv
// Combinational round-robin finder: returns the first requesting index at or
// above ptr, wrapping past N_SLAVES-1 back to 0.
module rr_arbiter #(
   parameter int N_SLAVES = 3,
   parameter int PW       = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
   input  logic [N_SLAVES-1:0] req,
   input  logic [PW-1:0]       ptr,
   output logic [PW-1:0]       grant,
   output logic                any_req
);

   int idx;

   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_SLAVES; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_SLAVES) idx = idx - N_SLAVES;
         if (!any_req && req[PW'(idx)]) begin
            any_req = 1'b1;
            grant   = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/spi_rx_packer.sv
// Drains per-slave SPI response FIFOs into the host TX byte stream as framed
// packets [hdr, len, payload..]; define SPI_RX_CHECKSUM_EN to append an XOR byte.
module spi_rx_packer
   import spi_rx_pkg::*;
#(
   parameter int         N_SLAVES    = 3,
   parameter logic [7:0] HDR_BASE    = HDR_BASE_DEF,
   parameter logic [7:0] MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
   input  logic                  sys_clk,
   input  logic                  n_rst,
   input  logic [N_SLAVES-1:0]   have_msg_bus,
   input  logic [8*N_SLAVES-1:0] len_bus,
   input  logic [8*N_SLAVES-1:0] s_dout_bus,
   output logic [N_SLAVES-1:0]   s_rdreq_bus,
   output logic [7:0]            tx_data,
   output logic                  tx_wrreq,
   input  logic                  tx_full,
   output logic                  busy,
   output logic [2:0]            state_dbg
);

   localparam int PW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   state_e          state_q, state_d;
   logic [PW-1:0]   sel_q, sel_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [PW-1:0]   grant;
   logic            any_req;
   logic [7:0]      len_arr  [N_SLAVES];
   logic [7:0]      dout_arr [N_SLAVES];

   for (genvar g = 0; g < N_SLAVES; g++) begin : g_unpack
      assign len_arr[g]  = len_bus[8*g +: 8];
      assign dout_arr[g] = s_dout_bus[8*g +: 8];
   end

   rr_arbiter #(
      .N_SLAVES (N_SLAVES),
      .PW       (PW)
   ) u_arb (
      .req     (have_msg_bus),
      .ptr     (ptr_q),
      .grant   (grant),
      .any_req (any_req)
   );

`ifdef SPI_RX_CHECKSUM_EN
   logic [7:0] xor_q, xor_d;
`endif

   // Outputs are decoded from state so tx_full gates the strobe in the same cycle.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      s_rdreq_bus = '0;
      tx_data     = 8'h00;
      tx_wrreq    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               sel_d   = grant;
               cnt_d   = cap_len(len_arr[grant], MAX_PAYLOAD);
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_DONE;
            end else if (!tx_full) begin
               tx_wrreq = 1'b1;
               tx_data  = HDR_BASE + 8'(sel_q);
               state_d  = ST_LEN;
            end
         end
         ST_LEN: begin
            if (!tx_full) begin
               tx_wrreq = 1'b1;
               tx_data  = cnt_q;
               state_d  = ST_RD;
            end
         end
         ST_RD: begin
            s_rdreq_bus = N_SLAVES'(1) << sel_q;
            state_d     = ST_WR;
         end
         ST_WR: begin
            if (!tx_full) begin
               tx_wrreq = 1'b1;
               tx_data  = dout_arr[sel_q];
               cnt_d    = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
`ifdef SPI_RX_CHECKSUM_EN
                  state_d = ST_CK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  state_d = ST_RD;
               end
            end
         end
`ifdef SPI_RX_CHECKSUM_EN
         ST_CK: begin
            if (!tx_full) begin
               tx_wrreq = 1'b1;
               tx_data  = xor_q;
               state_d  = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            ptr_d   = (sel_q == PW'(N_SLAVES - 1)) ? '0 : sel_q + PW'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef SPI_RX_CHECKSUM_EN
   always_comb begin
      xor_d = xor_q;
      if (state_q == ST_IDLE)  xor_d = 8'h00;
      else if (tx_wrreq)       xor_d = xor_q ^ tx_data;
   end

   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) xor_q <= 8'h00;
      else        xor_q <= xor_d;
   end
`endif

   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_rx_packer.sv
// Self-checking bench for spi_rx_packer: models the upstream FIFOs and predicts
// the framed byte stream from round-robin / cap rules (SPI_RX_CHECKSUM_EN aware).
module tb_spi_rx_packer;

   localparam int NS = 3;

   logic            sys_clk = 1'b0;
   logic            n_rst;
   logic [NS-1:0]   have_msg_bus;
   logic [8*NS-1:0] len_bus;
   logic [8*NS-1:0] s_dout_bus;
   logic [NS-1:0]   s_rdreq_bus;
   logic [7:0]      tx_data;
   logic            tx_wrreq;
   logic            tx_full;
   logic            busy;
   logic [2:0]      state_dbg;

   spi_rx_packer #(.N_SLAVES(NS)) dut (
      .sys_clk      (sys_clk),
      .n_rst        (n_rst),
      .have_msg_bus (have_msg_bus),
      .len_bus      (len_bus),
      .s_dout_bus   (s_dout_bus),
      .s_rdreq_bus  (s_rdreq_bus),
      .tx_data      (tx_data),
      .tx_wrreq     (tx_wrreq),
      .tx_full      (tx_full),
      .busy         (busy),
      .state_dbg    (state_dbg)
   );

   always #5 sys_clk = ~sys_clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   int         mptr  = 0;
   int         last_busy = -1;
   bit         rand_bp = 1'b0;
   logic [7:0] fifo [NS][$];
   logic [7:0] dout [NS];
   int         rd_cnt [NS];
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int         obs_cyc[$];

   // Protocol monitor: no write while full, at most one read request.
   always @(negedge sys_clk) begin
      if (n_rst === 1'b1) begin
         n_cmp++;
         if (tx_wrreq && tx_full) begin
            n_bad++;
            $display("FAIL wr_while_full: tx_wrreq=%b tx_full=%b cycle %0d, required no write", tx_wrreq, tx_full, cyc);
         end
         n_cmp++;
         if ($countones(s_rdreq_bus) > 1) begin
            n_bad++;
            $display("FAIL rdreq_onehot: s_rdreq_bus=%b cycle %0d, required at most one bit", s_rdreq_bus, cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic upd();
      for (int i = 0; i < NS; i++) begin
         have_msg_bus[i]     = (fifo[i].size() != 0);
         len_bus[8*i +: 8]   = 8'(fifo[i].size());
         s_dout_bus[8*i +: 8] = dout[i];
      end
   endtask

   task automatic cycle();
      logic [NS-1:0] rd;
      @(negedge sys_clk);
      rd = s_rdreq_bus;
      if (tx_wrreq) begin
         obs_q.push_back(tx_data);
         obs_cyc.push_back(cyc);
      end
      if (busy) last_busy = cyc;
      @(posedge sys_clk);
      #1;
      cyc++;
      for (int i = 0; i < NS; i++) begin
         if (rd[i]) begin
            rd_cnt[i]++;
            if (fifo[i].size() > 0) dout[i] = fifo[i].pop_front();
         end
      end
      if (rand_bp) tx_full = ($urandom_range(0, 3) == 0);
      upd();
   endtask

   task automatic run_idle(input int budget, input string name);
      int quiet = 0;
      int n = 0;
      while (quiet < 2 && n < budget) begin
         cycle();
         n++;
         if (!busy && have_msg_bus == '0) quiet++;
         else quiet = 0;
      end
      rand_bp = 1'b0;
      tx_full = 1'b0;
      n_cmp++;
      if (quiet < 2) begin
         n_bad++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
      end
   endtask

   // Reference: repeatedly pick first non-empty slave from ptr, emit one capped packet.
   task automatic predict();
      logic [7:0] m [NS][$];
      logic [7:0] b, x, n8, h;
      int s, n;
      for (int i = 0; i < NS; i++) m[i] = fifo[i];
      for (int guard = 0; guard < 64; guard++) begin
         s = -1;
         for (int k = 0; k < NS; k++)
            if (s < 0 && m[(mptr + k) % NS].size() > 0) s = (mptr + k) % NS;
         if (s < 0) break;
         n  = (m[s].size() > 64) ? 64 : m[s].size();
         n8 = 8'(n);
         h  = 8'h80 + 8'(s);
         exp_q.push_back(h);
         exp_q.push_back(n8);
         x = h ^ n8;
         for (int j = 0; j < n; j++) begin
            b = m[s].pop_front();
            exp_q.push_back(b);
            x = x ^ b;
         end
`ifdef SPI_RX_CHECKSUM_EN
         exp_q.push_back(x);
`endif
         mptr = (s + 1) % NS;
      end
   endtask

   task automatic start();
      obs_q.delete();
      obs_cyc.delete();
      exp_q.delete();
      for (int i = 0; i < NS; i++) rd_cnt[i] = 0;
   endtask

   task automatic load(input int s, input int n);
      for (int j = 0; j < n; j++) fifo[s].push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic clear_upstream();
      for (int i = 0; i < NS; i++) begin
         fifo[i].delete();
         dout[i] = 8'h00;
      end
      mptr = 0;
      upd();
   endtask

   task automatic test_reset();
      n_rst   = 1'b0;
      tx_full = 1'b0;
      clear_upstream();
      repeat (3) @(posedge sys_clk);
      #1;
      n_rst = 1'b1;
      @(negedge sys_clk);
      n_cmp++; if (tx_wrreq !== 1'b0)    begin n_bad++; $display("FAIL rst_wrreq: got %b want 0", tx_wrreq); end
      n_cmp++; if (tx_data !== 8'h00)    begin n_bad++; $display("FAIL rst_data: got %h want 00", tx_data); end
      n_cmp++; if (s_rdreq_bus !== '0)   begin n_bad++; $display("FAIL rst_rdreq: got %b want 000", s_rdreq_bus); end
      n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (state_dbg !== 3'd0)   begin n_bad++; $display("FAIL rst_state: got %0d want 0 (IDLE)", state_dbg); end
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_round_robin();
      logic [7:0] got;
      int pkt;
      pkt = 3;
`ifdef SPI_RX_CHECKSUM_EN
      pkt = 4;
`endif
      for (int phase = 0; phase < 2; phase++) begin
         if (phase == 1) begin
            // one packet on slave 0 moves the pointer to 1
            start(); load(0, 1); predict(); upd(); run_idle(50, "rr_prep");
         end
         start(); load(0, 1); load(2, 1); predict(); upd();
         run_idle(80, "rr");
         n_cmp++;
         if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL rr_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
            if (got !== exp_q[i]) begin n_bad++; $display("FAIL rr_byte%0d: got %h want %h", i, got, exp_q[i]); end
         end
         got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
         n_cmp++;
         if (got !== ((phase == 0) ? 8'h80 : 8'h82)) begin
            n_bad++; $display("FAIL rr_first_hdr: phase %0d got %h want %h", phase, got, (phase == 0) ? 8'h80 : 8'h82);
         end
         got = (obs_q.size() > pkt) ? obs_q[pkt] : 8'hxx;
         n_cmp++;
         if (got !== ((phase == 0) ? 8'h82 : 8'h80)) begin
            n_bad++; $display("FAIL rr_second_hdr: phase %0d got %h want %h", phase, got, (phase == 0) ? 8'h82 : 8'h80);
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] got;
      int load_cyc, tail;
      start();
      fifo[1].push_back(8'hA5);
      fifo[1].push_back(8'h3C);
      predict();
      exp_q.delete();
      exp_q.push_back(8'h81); exp_q.push_back(8'h02); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
      tail = 6;
`ifdef SPI_RX_CHECKSUM_EN
      exp_q.push_back(8'h81 ^ 8'h02 ^ 8'hA5 ^ 8'h3C);
      tail = 7;
`endif
      load_cyc = cyc;
      upd();
      run_idle(50, "single");
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_bad++; $display("FAIL single_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
         if (got !== exp_q[i]) begin n_bad++; $display("FAIL single_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
      n_cmp++;
      if (rd_cnt[1] !== 2 || rd_cnt[0] !== 0 || rd_cnt[2] !== 0) begin
         n_bad++; $display("FAIL single_rdreq: got %0d/%0d/%0d pulses want 0/2/0", rd_cnt[0], rd_cnt[1], rd_cnt[2]);
      end
      n_cmp++;
      if (obs_cyc.size() < 4) begin
         n_bad++; $display("FAIL single_timing: got %0d writes want at least 4", obs_cyc.size());
      end else begin
         n_cmp++;
         if (obs_cyc[0] !== load_cyc + 1) begin
            n_bad++; $display("FAIL single_latency: header at edge %0d want %0d", obs_cyc[0] - load_cyc + 1, 2);
         end
         n_cmp++;
         if (obs_cyc[1] - obs_cyc[0] !== 1 || obs_cyc[2] - obs_cyc[0] !== 3 || obs_cyc[3] - obs_cyc[0] !== 5) begin
            n_bad++; $display("FAIL single_spacing: got +%0d,+%0d,+%0d want +1,+3,+5",
                              obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[0], obs_cyc[3] - obs_cyc[0]);
         end
         n_cmp++;
         if (last_busy - obs_cyc[0] !== tail) begin
            n_bad++; $display("FAIL single_done: last busy at +%0d want +%0d", last_busy - obs_cyc[0], tail);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] got;
      int s, n, rc;
      start();
      s = $urandom_range(0, NS - 1);
      load(s, 3);
      predict();
      upd();
      n = 0;
      while (rd_cnt[s] < 2 && n < 40) begin cycle(); n++; end
      n_cmp++;
      if (rd_cnt[s] < 2) begin n_bad++; $display("FAIL bp_reach_wr: got %0d rdreq want 2", rd_cnt[s]); end
      tx_full = 1'b1;
      rc = rd_cnt[s];
      repeat (5) cycle();
      n_cmp++;
      if (rd_cnt[s] !== rc) begin n_bad++; $display("FAIL bp_extra_rdreq: got %0d pulses want %0d", rd_cnt[s], rc); end
      n_cmp++;
      if (obs_q.size() !== 3) begin n_bad++; $display("FAIL bp_hold: got %0d writes want 3", obs_q.size()); end
      tx_full = 1'b0;
      run_idle(60, "bp");
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_bad++; $display("FAIL bp_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
         if (got !== exp_q[i]) begin n_bad++; $display("FAIL bp_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
      n_cmp++;
      if (rd_cnt[s] !== 3) begin n_bad++; $display("FAIL bp_rdreq_total: got %0d want 3", rd_cnt[s]); end
   endtask

   task automatic test_cap_split();
      logic [7:0] got;
      int s, o;
      start();
      s = $urandom_range(0, NS - 1);
      o = (s + 1) % NS;
      load(s, 70);
      load(o, $urandom_range(1, 4));
      predict();
      upd();
      run_idle(600, "split");
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_bad++; $display("FAIL split_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
         if (got !== exp_q[i]) begin n_bad++; $display("FAIL split_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
      n_cmp++;
      if (rd_cnt[s] !== 70) begin n_bad++; $display("FAIL split_rdreq: got %0d want 70", rd_cnt[s]); end
   endtask

   task automatic test_random();
      logic [7:0] got;
      int mask;
      for (int r = 0; r < 6; r++) begin
         start();
         mask = $urandom_range(1, (1 << NS) - 1);
         for (int i = 0; i < NS; i++) if (mask[i]) load(i, $urandom_range(1, 20));
         predict();
         upd();
         rand_bp = 1'b1;
         run_idle(500, "rand");
         n_cmp++;
         if (obs_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL rand%0d_count: got %0d bytes want %0d", r, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
            if (got !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", r, i, got, exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got;
      int n;
      start();
      load(2, 5);
      predict();
      upd();
      n = 0;
      while (obs_q.size() < 4 && n < 40) begin cycle(); n++; end
      #2;
      n_rst = 1'b0;
      #1;
      n_cmp++; if (tx_wrreq !== 1'b0)  begin n_bad++; $display("FAIL midrst_wrreq: got %b want 0", tx_wrreq); end
      n_cmp++; if (tx_data !== 8'h00)  begin n_bad++; $display("FAIL midrst_data: got %h want 00", tx_data); end
      n_cmp++; if (s_rdreq_bus !== '0) begin n_bad++; $display("FAIL midrst_rdreq: got %b want 000", s_rdreq_bus); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", state_dbg); end
      clear_upstream();
      repeat (2) @(posedge sys_clk);
      #1;
      n_rst = 1'b1;
      start();
      repeat (5) cycle();
      n_cmp++;
      if (obs_q.size() !== 0) begin n_bad++; $display("FAIL midrst_spurious: got %0d writes want 0", obs_q.size()); end
      start();
      for (int i = 0; i < NS; i++) load(i, 1);
      predict();
      upd();
      run_idle(100, "midrst");
      got = (obs_q.size() > 0) ? obs_q[0] : 8'hxx;
      n_cmp++;
      if (got !== 8'h80) begin n_bad++; $display("FAIL midrst_ptr: first header %h want 80", got); end
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_bad++; $display("FAIL midrst_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
         if (got !== exp_q[i]) begin n_bad++; $display("FAIL midrst_byte%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

`ifdef SPI_RX_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] got;
      logic [7:0] want [5];
      want[0] = 8'h80; want[1] = 8'h02; want[2] = 8'h01; want[3] = 8'h02; want[4] = 8'h81;
      start();
      fifo[0].push_back(8'h01);
      fifo[0].push_back(8'h02);
      predict();
      upd();
      run_idle(50, "ck");
      n_cmp++;
      if (obs_q.size() !== 5) begin n_bad++; $display("FAIL ck_count: got %0d bytes want 5", obs_q.size()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         got = (i < obs_q.size()) ? obs_q[i] : 8'hxx;
         if (got !== want[i]) begin n_bad++; $display("FAIL ck_byte%0d: got %h want %h", i, got, want[i]); end
      end
   endtask
`endif

   initial begin
      have_msg_bus = '0;
      len_bus      = '0;
      s_dout_bus   = '0;
      tx_full      = 1'b0;
      n_rst        = 1'b0;
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_cap_split();
      test_random();
      test_reset_mid();
`ifdef SPI_RX_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
